// File: rtl/tl_pkg.sv
// ============================================================================
//  Module      : tl_pkg
//  Description : Shared encodings, sizes and select helpers for the route stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tl_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } tl_state_e;

    localparam int NUM_CH    = 4;
    localparam int DEST_W    = 2;
    localparam int TL_DATA_W = 6;

    // Index of the set bit; only meaningful for a one-hot input.
    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        if (oh[1]) idx = 2'd1;
        if (oh[2]) idx = 2'd2;
        if (oh[3]) idx = 2'd3;
        return idx;
    endfunction

    function automatic logic multi_hot(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tl_route_stage_if.sv
// ============================================================================
//  Module      : tl_route_if
//  Description : Arbiter pops / orange read data in, purple push strobes out.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tl_route_if #(
    parameter int DATA_W = 6
);
    logic              push;
    logic              pop0, pop1, pop2, pop3;
    logic [DATA_W-1:0] data_in0, data_in1, data_in2, data_in3;
    logic              push_out0, push_out1, push_out2, push_out3;
    logic [DATA_W-1:0] data_out;

    modport master (
        output push, pop0, pop1, pop2, pop3,
        output data_in0, data_in1, data_in2, data_in3,
        input  push_out0, push_out1, push_out2, push_out3, data_out
    );

    modport slave (
        input  push, pop0, pop1, pop2, pop3,
        input  data_in0, data_in1, data_in2, data_in3,
        output push_out0, push_out1, push_out2, push_out3, data_out
    );
endinterface

`default_nettype wire

// File: rtl/tl_route_counter.sv
// ============================================================================
//  Module      : tl_route_counter
//  Description : Wrapping per-destination packet counter with sync clear.
//                Only present when TL_ROUTE_CNT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef TL_ROUTE_CNT_EN
module tl_route_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
endmodule
`endif

`default_nettype wire

// File: rtl/tl_route_stage.sv
// ============================================================================
//  Module      : tl_route_stage
//  Description : Two-stage mux/route from orange ingress to purple egress FIFOs.
//                Optional per-destination counters under TL_ROUTE_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_route_stage
    import tl_pkg::*;
#(
    parameter int DATA_W = TL_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [3:0] state,
    tl_route_if.slave  bus,
    output logic       sel_error
`ifdef TL_ROUTE_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
`endif
);
    logic [NUM_CH-1:0] w_pops;
    logic [DATA_W-1:0] w_din [NUM_CH];
    logic              w_sync_clr;
    logic [DATA_W-1:0] w_word;
    logic [DEST_W-1:0] w_dest;

    logic [NUM_CH-1:0] r_sel;
    logic              r_v1;
    logic [NUM_CH-1:0] r_push;
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    assign w_pops     = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
    assign w_din[0]   = bus.data_in0;
    assign w_din[1]   = bus.data_in1;
    assign w_din[2]   = bus.data_in2;
    assign w_din[3]   = bus.data_in3;
    assign w_sync_clr = (state == ST_RESET);

    // FIFO read data lags its pop by a cycle, so the mux uses the registered select.
    always_comb begin
        w_word = w_din[onehot_idx(r_sel)];
        w_dest = w_word[DATA_W-1 -: DEST_W];
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_sel  <= '0;
            r_v1   <= 1'b0;
            r_push <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_sync_clr) begin
            r_sel  <= '0;
            r_v1   <= 1'b0;
            r_push <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else begin
            r_sel <= w_pops;
            r_v1  <= bus.push && (w_pops != '0) && !multi_hot(w_pops);
            if (multi_hot(w_pops)) begin
                r_err <= 1'b1;
            end
            if (r_v1) begin
                r_data <= w_word;
                r_push <= NUM_CH'(1) << w_dest;
            end else begin
                r_push <= '0;
            end
        end
    end

    assign bus.push_out0 = r_push[0];
    assign bus.push_out1 = r_push[1];
    assign bus.push_out2 = r_push[2];
    assign bus.push_out3 = r_push[3];
    assign bus.data_out  = r_data;
    assign sel_error     = r_err;

`ifdef TL_ROUTE_CNT_EN
    logic [CNT_W-1:0] w_cnt [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
        tl_route_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset_L (reset_L),
            .clr     (w_sync_clr),
            .inc     (r_push[i]),
            .count   (w_cnt[i])
        );
    end

    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
    assign cnt2 = w_cnt[2];
    assign cnt3 = w_cnt[3];
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tl_route_stage.sv
// ============================================================================
//  Module      : tb_tl_route_stage
//  Description : Scoreboard bench for tl_route_stage (counters with TL_ROUTE_CNT_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tl_route_stage;
    import tl_pkg::*;

    localparam int DATA_W = 6;
    localparam int CNT_W  = 8;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [3:0] state;
    logic       sel_error;
`ifdef TL_ROUTE_CNT_EN
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
`endif

    tl_route_if #(.DATA_W(DATA_W)) bus ();

    tl_route_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .state     (state),
        .bus       (bus),
        .sel_error (sel_error)
`ifdef TL_ROUTE_CNT_EN
        ,
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [5:0]  word;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         exp_cnt [4];
    logic [5:0] last_data;
    logic       exp_err;
    logic [3:0] pend_pop;
    logic [5:0] pend_word;
    logic [3:0] obs;
    logic [3:0] ev;

    function automatic logic [3:0] exp_vec();
        if (q.size() != 0 && q[0].due == cyc)
            return 4'b0001 << q[0].word[5:4];
        return 4'b0000;
    endfunction

    // Drive one cycle of stimulus and record what the scoreboard must see.
    task automatic tick(input logic [3:0] pops, input logic p, input logic [5:0] word);
        bus.pop0 = pops[0];
        bus.pop1 = pops[1];
        bus.pop2 = pops[2];
        bus.pop3 = pops[3];
        bus.push = p;
        bus.data_in0 = 6'($urandom);
        bus.data_in1 = 6'($urandom);
        bus.data_in2 = 6'($urandom);
        bus.data_in3 = 6'($urandom);
        case (pend_pop)
            4'b0001: bus.data_in0 = pend_word;
            4'b0010: bus.data_in1 = pend_word;
            4'b0100: bus.data_in2 = pend_word;
            4'b1000: bus.data_in3 = pend_word;
            default: ;
        endcase
        if (state == ST_RESET) begin
            q.delete();
            for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
            last_data = '0;
            exp_err   = 1'b0;
        end else begin
            if (p && pops != 4'b0 && (pops & (pops - 4'd1)) == 4'b0)
                q.push_back('{cyc + 2, word});
            if ((pops & (pops - 4'd1)) != 4'b0)
                exp_err = 1'b1;
        end
        pend_pop  = pops;
        pend_word = word;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        state   = ST_RESET;
        pend_pop = '0;
        bus.push = 1'b0;
        {bus.pop3, bus.pop2, bus.pop1, bus.pop0} = 4'b0;
        {bus.data_in3, bus.data_in2, bus.data_in1, bus.data_in0} = '0;
        repeat (2) @(posedge clk);
        #1;
        obs = {bus.push_out3, bus.push_out2, bus.push_out1, bus.push_out0};
        total++;
        if (obs !== 4'b0) begin bad++; $display("FAIL reset_push got=%b want=0000", obs); end
        total++;
        if (bus.data_out !== 6'b0) begin bad++; $display("FAIL reset_data got=%b want=000000", bus.data_out); end
        total++;
        if (sel_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", sel_error); end
`ifdef TL_ROUTE_CNT_EN
        total++;
        if ({cnt3, cnt2, cnt1, cnt0} !== '0) begin bad++; $display("FAIL reset_cnt got=%h want=0", {cnt3, cnt2, cnt1, cnt0}); end
`endif
        reset_L = 1'b1;
        state   = ST_ACTIVE;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        last_data = '0;
        exp_err   = 1'b0;
        q.delete();
    endtask

    task automatic test_single_beat();
        for (int i = 0; i < 5; i++) begin
            if (i == 0) tick(4'b0100, 1'b1, 6'b011010);
            else        tick(4'b0000, 1'b1, 6'b0);
            obs = {bus.push_out3, bus.push_out2, bus.push_out1, bus.push_out0};
            ev  = exp_vec();
            total++;
            if (obs !== ev) begin bad++; $display("FAIL single_push cyc=%0d got=%b want=%b", cyc, obs, ev); end
            if (ev != 4'b0) begin
                last_data = q[0].word;
                exp_cnt[q[0].word[5:4]]++;
                void'(q.pop_front());
            end
            total++;
            if (bus.data_out !== last_data) begin bad++; $display("FAIL single_data cyc=%0d got=%b want=%b", cyc, bus.data_out, last_data); end
        end
`ifdef TL_ROUTE_CNT_EN
        total++;
        if (cnt1 !== CNT_W'(exp_cnt[1])) begin bad++; $display("FAIL single_cnt1 got=%0d want=%0d", cnt1, exp_cnt[1]); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [5:0] words [4];
        words[0] = 6'b00_0101;
        words[1] = 6'b01_1100;
        words[2] = 6'b10_0011;
        words[3] = 6'b11_1110;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) tick(4'b0001, 1'b1, words[i]);
            else       tick(4'b0000, 1'b1, 6'b0);
            obs = {bus.push_out3, bus.push_out2, bus.push_out1, bus.push_out0};
            ev  = exp_vec();
            total++;
            if (obs !== ev) begin bad++; $display("FAIL b2b_push cyc=%0d got=%b want=%b", cyc, obs, ev); end
            if (ev != 4'b0) begin
                last_data = q[0].word;
                exp_cnt[q[0].word[5:4]]++;
                void'(q.pop_front());
            end
            total++;
            if (bus.data_out !== last_data) begin bad++; $display("FAIL b2b_data cyc=%0d got=%b want=%b", cyc, bus.data_out, last_data); end
        end
`ifdef TL_ROUTE_CNT_EN
        total++;
        if ({cnt3, cnt2, cnt1, cnt0} !== {CNT_W'(exp_cnt[3]), CNT_W'(exp_cnt[2]), CNT_W'(exp_cnt[1]), CNT_W'(exp_cnt[0])}) begin
            bad++; $display("FAIL b2b_cnt got=%h want=%0d,%0d,%0d,%0d", {cnt3, cnt2, cnt1, cnt0}, exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]);
        end
`endif
    endtask

    task automatic test_push_gated();
        for (int i = 0; i < 4; i++) begin
            if (i == 0) tick(4'b0010, 1'b0, 6'b11_0101);
            else        tick(4'b0000, 1'b1, 6'b0);
            obs = {bus.push_out3, bus.push_out2, bus.push_out1, bus.push_out0};
            ev  = exp_vec();
            total++;
            if (obs !== ev) begin bad++; $display("FAIL gated_push cyc=%0d got=%b want=%b", cyc, obs, ev); end
            if (ev != 4'b0) begin
                last_data = q[0].word;
                exp_cnt[q[0].word[5:4]]++;
                void'(q.pop_front());
            end
            total++;
            if (bus.data_out !== last_data) begin bad++; $display("FAIL gated_data cyc=%0d got=%b want=%b", cyc, bus.data_out, last_data); end
        end
`ifdef TL_ROUTE_CNT_EN
        total++;
        if (cnt3 !== CNT_W'(exp_cnt[3])) begin bad++; $display("FAIL gated_cnt3 got=%0d want=%0d", cnt3, exp_cnt[3]); end
`endif
    endtask

    task automatic test_illegal_select();
        for (int i = 0; i < 6; i++) begin
            if (i == 0)      tick(4'b1001, 1'b1, 6'b11_0000);
            else if (i == 4) begin state = ST_RESET; tick(4'b0000, 1'b1, 6'b0); state = ST_ACTIVE; end
            else             tick(4'b0000, 1'b1, 6'b0);
            obs = {bus.push_out3, bus.push_out2, bus.push_out1, bus.push_out0};
            ev  = exp_vec();
            total++;
            if (obs !== ev) begin bad++; $display("FAIL illegal_push cyc=%0d got=%b want=%b", cyc, obs, ev); end
            if (ev != 4'b0) begin
                last_data = q[0].word;
                void'(q.pop_front());
            end
            total++;
            if (sel_error !== exp_err) begin bad++; $display("FAIL illegal_err cyc=%0d got=%b want=%b", cyc, sel_error, exp_err); end
            total++;
            if (bus.data_out !== last_data) begin bad++; $display("FAIL illegal_data cyc=%0d got=%b want=%b", cyc, bus.data_out, last_data); end
        end
    endtask

    task automatic test_reset_midflight();
        tick(4'b0001, 1'b1, 6'b10_0111);
        #1;
        reset_L = 1'b0;
        #1;
        obs = {bus.push_out3, bus.push_out2, bus.push_out1, bus.push_out0};
        total++;
        if (obs !== 4'b0 || bus.data_out !== 6'b0 || sel_error !== 1'b0) begin
            bad++; $display("FAIL midflight_async push=%b data=%b err=%b want=0", obs, bus.data_out, sel_error);
        end
`ifdef TL_ROUTE_CNT_EN
        total++;
        if ({cnt3, cnt2, cnt1, cnt0} !== '0) begin bad++; $display("FAIL midflight_cnt got=%h want=0", {cnt3, cnt2, cnt1, cnt0}); end
`endif
        q.delete();
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        last_data = '0;
        exp_err   = 1'b0;
        tick(4'b0000, 1'b1, 6'b0);
        reset_L  = 1'b1;
        pend_pop = '0;
        for (int i = 0; i < 3; i++) begin
            tick(4'b0000, 1'b1, 6'b0);
            obs = {bus.push_out3, bus.push_out2, bus.push_out1, bus.push_out0};
            total++;
            if (obs !== 4'b0 || bus.data_out !== 6'b0) begin
                bad++; $display("FAIL midflight_after cyc=%0d push=%b data=%b want=0", cyc, obs, bus.data_out);
            end
        end
    endtask

`ifdef TL_ROUTE_CNT_EN
    task automatic test_counter_wrap();
        state = ST_RESET;
        tick(4'b0000, 1'b1, 6'b0);
        state = ST_ACTIVE;
        for (int i = 0; i < 259; i++) begin
            if (i < 256) tick(4'b0010, 1'b1, 6'($urandom) & 6'h0f);
            else         tick(4'b0000, 1'b1, 6'b0);
            obs = {bus.push_out3, bus.push_out2, bus.push_out1, bus.push_out0};
            ev  = exp_vec();
            total++;
            if (obs !== ev) begin bad++; $display("FAIL wrap_push cyc=%0d got=%b want=%b", cyc, obs, ev); end
            if (ev != 4'b0) begin
                last_data = q[0].word;
                exp_cnt[q[0].word[5:4]]++;
                void'(q.pop_front());
            end
        end
        total++;
        if (cnt0 !== CNT_W'(exp_cnt[0]) || cnt0 !== 8'd0) begin bad++; $display("FAIL wrap_cnt0 got=%0d want=0", cnt0); end
        total++;
        if ({cnt3, cnt2, cnt1} !== '0) begin bad++; $display("FAIL wrap_others got=%h want=0", {cnt3, cnt2, cnt1}); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_beat();
        test_back_to_back();
        test_push_gated();
        test_illegal_select();
        test_reset_midflight();
`ifdef TL_ROUTE_CNT_EN
        test_counter_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tl_route_stage.md
Name: tl_route_stage

Overview:
- Datapath stage directly downstream of the transaction-layer arbiter.
- Takes the arbiter's one-hot pop0..pop3 and the read data of the four orange (ingress) FIFOs.
- Muxes the popped word, decodes its destination field and pushes it into one of the four purple (egress) FIFOs.
- Two-cycle pipeline, with per-destination statistics and illegal-select detection.

Parameters:
- DATA_W, 6, width of a FIFO word; the two MSBs are the destination field.
- CNT_W, 8, width of each per-destination packet counter.

Ports:
- clk  in  1  system clock, rising edge
- reset_L  in  1  asynchronous active-low reset
- state  in  4  control FSM state, one-hot; 4'b0001 = RESET
- push  in  1  arbiter push enable; 0 suppresses all egress pushes
- pop0..pop3  in  1 each  arbiter pops to orange FIFOs 0..3
- data_in0..data_in3  in  DATA_W each  orange FIFO read data, valid the cycle after that FIFO's pop
- push_out0..push_out3  out  1 each  push strobes to purple FIFOs 0..3
- data_out  out  DATA_W  word presented to all purple FIFOs
- sel_error  out  1  sticky flag: more than one pop seen in one cycle
- cnt0..cnt3  out  CNT_W each  packets pushed per destination (optional feature only)

Behaviour:
- Reset (reset_L=0, async): all outputs, pipeline registers and counters go to 0 immediately.
- Synchronous clear: when state==4'b0001, the same clear applies on the next clk edge, and it overrides all other activity in that cycle.
- Stage 1 (cycle N): register sel_q = {pop3..pop0} and v1 = |pops & push.
- Stage 2 (cycle N+1):
  - If v1: mux word = data_in[index of sel_q] and dest = word[DATA_W-1:DATA_W-2].
  - Register data_out = word, push_outX = 1 only for X==dest, for exactly one cycle.
- Latency: pop asserted at edge N gives push_out at edge N+2. Throughput is one word per cycle; back-to-back pops give back-to-back pushes.
- Illegal select: more than one pop in a cycle.
  - Sets sel_error on the next edge; it stays set until reset or RESET state.
  - That beat is dropped (v1=0); no push is produced.
- push=0 in the pop cycle drops the beat. Beats already in stage 2 still complete.
- No pops: push_out all 0, and data_out holds its last value.
- almost_full is not checked here; the arbiter's gating is the sole backpressure. Two words can be in flight after almost_full rises, so purple FIFO thresholds must leave at least 2 free slots.
- Entering RESET mid-pipeline: in-flight beats are discarded and no push is emitted afterwards.
- data_out changes only on the cycle a push_out is asserted.

Optional Feature:
- Macro TL_ROUTE_CNT_EN.
- Defined: cnt0..cnt3 ports exist. cntX increments by 1 on every cycle push_outX=1 and wraps from 2^CNT_W-1 to 0. It is cleared by reset or RESET state.
- Undefined: cnt ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package tl_pkg:
  - state encodings: ST_RESET=4'b0001, ST_INIT=4'b0010, ST_IDLE=4'b0100, ST_ACTIVE=4'b1000
  - NUM_CH=4, DEST_W=2, default DATA_W
- One natural sub-module, tl_route_counter: a CNT_W wrapping counter with inc and sync clear. It is instantiated four times under TL_ROUTE_CNT_EN.

Test Plan:
- Single beat: state=ACTIVE, push=1, pop2 pulse, data_in2=6'b01_1010 the next cycle → two cycles after pop, push_out1=1 for one cycle, data_out=6'b011010, and cnt1=1.
- Back-to-back: pop0 for 4 consecutive cycles with data dest 0,1,2,3 → push_out0..3 asserted on 4 consecutive cycles in order, no gaps.
- Illegal select: pop0 and pop3 high together → sel_error=1 next edge, no push_out; sel_error stays 1 until state=4'b0001.
- Push gated: push=0 with pop1=1, data dest 3 → push_out3 never asserts and counters are unchanged.
- Reset mid-flight: pop0 at N, reset_L low at N+1 (async) → all outputs 0 immediately, no push at N+2, counters 0.
- Counter wrap (TL_ROUTE_CNT_EN): 256 beats to dest 0 with CNT_W=8 → cnt0 returns to 0 and the other counters stay 0.
